// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM state encoding, default address and
// the address-compare helper used when the address byte completes.
package i2c_pkg;

    typedef logic [2:0] slave_state_t;

    localparam slave_state_t ST_IDLE     = 3'd0;
    localparam slave_state_t ST_ADDR     = 3'd1;
    localparam slave_state_t ST_ADDR_ACK = 3'd2;
    localparam slave_state_t ST_WR_DATA  = 3'd3;
    localparam slave_state_t ST_WR_ACK   = 3'd4;
    localparam slave_state_t ST_RD_DATA  = 3'd5;
    localparam slave_state_t ST_RD_ACK   = 3'd6;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

    // True when the 7-bit address field of a received address byte is ours.
    function automatic logic addr_match(input logic [6:0] addr_field,
                                        input logic [6:0] own_addr);
        return addr_field == own_addr;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings the asynchronous scl/sda lines into the sys_clk domain and derives
// scl edges plus START/STOP conditions from the synchronized copies only.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_sync,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_pipe_reg;
    logic [SYNC_STAGES-1:0] sda_pipe_reg;
    logic                   scl_prev_reg;
    logic                   sda_prev_reg;
    logic                   scl_sync;

    // Synchronizer chains; idle bus level is high so they reset to 1.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            scl_pipe_reg <= '1;
            sda_pipe_reg <= '1;
        end else begin
            scl_pipe_reg <= {scl_pipe_reg[SYNC_STAGES-2:0], scl};
            sda_pipe_reg <= {sda_pipe_reg[SYNC_STAGES-2:0], sda};
        end
    end

    // One-cycle-delayed copies for edge detection.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_prev_reg <= scl_sync;
            sda_prev_reg <= sda_sync;
        end
    end

    assign scl_sync  = scl_pipe_reg[SYNC_STAGES-1];
    assign sda_sync  = sda_pipe_reg[SYNC_STAGES-1];
    assign scl_rise  = scl_sync & ~scl_prev_reg;
    assign scl_fall  = ~scl_sync & scl_prev_reg;
    // sda may only move while scl is low during data; a move with scl held
    // high across both samples is a bus condition.
    assign start_det = scl_sync & scl_prev_reg & sda_prev_reg & ~sda_sync;
    assign stop_det  = scl_sync & scl_prev_reg & ~sda_prev_reg & sda_sync;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave: 7-bit address match, unbounded multi-byte writes and reads,
// open-drain sda with drive changes only after scl falling edges.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_rw,
    output logic       busy
);

    logic         sda_sync;
    logic         scl_rise;
    logic         scl_fall;
    logic         start_det;
    logic         stop_det;

    slave_state_t state_reg;
    logic [2:0]   bit_cnt_reg;
    // Holds the 7 bits preceding the current one: on receive the byte is
    // completed by the live sda bit, on transmit the MSB goes straight to sda.
    logic [6:0]   shift_reg;
    logic         sda_low_reg;
    // ACK states: set once the ACK drive has begun. RD_ACK: master acked.
    logic         ack_hold_reg;
    logic [7:0]   rx_data_reg;
    logic         rx_valid_reg;
    logic         rx_rw_reg;
    logic         busy_reg;
    logic         tx_load_reg;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .sda_sync (sda_sync),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    // Protocol FSM: bus conditions take priority over any same-cycle scl edge.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 7'd0;
            sda_low_reg  <= 1'b0;
            ack_hold_reg <= 1'b0;
            rx_data_reg  <= 8'd0;
            rx_valid_reg <= 1'b0;
            rx_rw_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            tx_load_reg  <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            tx_load_reg  <= 1'b0;
            if (stop_det) begin
                state_reg    <= ST_IDLE;
                sda_low_reg  <= 1'b0;
                busy_reg     <= 1'b0;
                bit_cnt_reg  <= 3'd0;
                ack_hold_reg <= 1'b0;
            end else if (start_det) begin
                state_reg    <= ST_ADDR;
                sda_low_reg  <= 1'b0;
                busy_reg     <= 1'b0;
                bit_cnt_reg  <= 3'd0;
                ack_hold_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[5:0], sda_sync};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                if (addr_match(shift_reg, SLAVE_ADDR)) begin
                                    state_reg <= ST_ADDR_ACK;
                                    rx_rw_reg <= sda_sync;
                                    busy_reg  <= 1'b1;
                                end else begin
                                    state_reg   <= ST_IDLE;
                                    sda_low_reg <= 1'b0;
                                    busy_reg    <= 1'b0;
                                end
                            end
                        end
                    end

                    ST_ADDR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_hold_reg) begin
                                sda_low_reg  <= 1'b1;
                                ack_hold_reg <= 1'b1;
                            end else begin
                                ack_hold_reg <= 1'b0;
                                bit_cnt_reg  <= 3'd0;
                                if (state_reg == ST_ADDR_ACK && rx_rw_reg) begin
                                    state_reg   <= ST_RD_DATA;
                                    shift_reg   <= tx_data[6:0];
                                    tx_load_reg <= 1'b1;
                                    sda_low_reg <= ~tx_data[7];
                                end else begin
                                    state_reg   <= ST_WR_DATA;
                                    sda_low_reg <= 1'b0;
                                end
                            end
                        end
                    end

                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[5:0], sda_sync};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                rx_data_reg  <= {shift_reg, sda_sync};
                                rx_valid_reg <= 1'b1;
                                state_reg    <= ST_WR_ACK;
                            end
                        end
                    end

                    ST_RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt_reg == 3'd7) begin
                                sda_low_reg  <= 1'b0;
                                bit_cnt_reg  <= 3'd0;
                                ack_hold_reg <= 1'b0;
                                state_reg    <= ST_RD_ACK;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                                sda_low_reg <= ~shift_reg[6];
                                shift_reg   <= {shift_reg[5:0], 1'b0};
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_sync) begin
                                state_reg   <= ST_IDLE;
                                sda_low_reg <= 1'b0;
                            end else begin
                                ack_hold_reg <= 1'b1;
                            end
                        end else if (scl_fall && ack_hold_reg) begin
                            ack_hold_reg <= 1'b0;
                            bit_cnt_reg  <= 3'd0;
                            state_reg    <= ST_RD_DATA;
                            shift_reg    <= tx_data[6:0];
                            tx_load_reg  <= 1'b1;
                            sda_low_reg  <= ~tx_data[7];
                        end
                    end

                    default: begin
                        state_reg    <= ST_IDLE;
                        sda_low_reg  <= 1'b0;
                        ack_hold_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Open drain; gating with rst releases the line the instant reset asserts.
    assign sda = (sda_low_reg && rst) ? 1'b0 : 1'bz;

    assign tx_load  = tx_load_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign rx_rw    = rx_rw_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed + randomized bench for i2c_slave acting as a bus master.
module tb_i2c_slave;

    localparam int Q = 40;
    localparam int H = 80;

    logic       sys_clk   = 1'b0;
    logic       rst       = 1'b0;
    logic       scl       = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    wire        sda;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_rw;
    logic       busy;

    int checks        = 0;
    int failures      = 0;
    int tx_load_cnt   = 0;
    int slave_low_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave #(
        .SLAVE_ADDR (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .scl     (scl),
        .sda     (sda),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_rw   (rx_rw),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Observe pulses and slave drive away from the active edge.
    always @(negedge sys_clk) begin
        if (tx_load === 1'b1) tx_load_cnt <= tx_load_cnt + 1;
        if (rx_valid === 1'b1) got_q.push_back(rx_data);
        if (!m_sda_low && sda === 1'b0) slave_low_cnt <= slave_low_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference rule: the slave answers only its own 7-bit address.
    function automatic logic addressed(input logic [7:0] addr_byte);
        return addr_byte[7:1] == 7'h50;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_rx_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_rx_byte"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #H;
        m_sda_low = 1'b1; #H;
        scl = 1'b0;       #Q;
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; #Q;
        scl = 1'b1;       #H;
        m_sda_low = 1'b0; #H;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic clock_bit(input logic drive_bit, output logic sampled);
        m_sda_low = ~drive_bit; #Q;
        scl = 1'b1;             #(H/2);
        sampled = sda;          #(H/2);
        scl = 1'b0;             #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        acked = (s === 1'b0);
    endtask

    task automatic read_byte(input logic master_ack, input logic [7:0] next_tx,
                             output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        tx_data = next_tx;
        clock_bit(~master_ack, s);
    endtask

    task automatic write_txn(input logic [7:0] addr_byte, input int nbytes,
                             input logic use_fixed, input logic [7:0] fixed_data,
                             input string tag);
        logic       ack;
        logic       hit;
        logic [7:0] d;
        int         low0;
        hit  = addressed(addr_byte);
        low0 = slave_low_cnt;
        bus_start();
        write_byte(addr_byte, ack);
        check({tag, "_addr_ack"}, ack, hit);
        check({tag, "_busy"}, busy, hit);
        for (int i = 0; i < nbytes; i++) begin
            d = use_fixed ? fixed_data : 8'($urandom);
            write_byte(d, ack);
            check({tag, "_data_ack"}, ack, hit);
            if (hit) exp_q.push_back(d);
        end
        bus_stop();
        check({tag, "_busy_after_stop"}, busy, 1'b0);
        check({tag, "_sda_idle"}, sda, 1'b1);
        if (!hit) check({tag, "_never_low"}, slave_low_cnt - low0, 0);
        compare_rx(tag);
        $display("txn %s addr=%02h bytes=%0d hit=%0b", tag, addr_byte, nbytes, hit);
    endtask

    task automatic read_txn(input int nbytes, input logic use_fixed,
                            input logic [7:0] fixed_tx, input string tag);
        logic       ack;
        logic [7:0] cur;
        logic [7:0] nxt;
        logic [7:0] got;
        int         load0;
        cur     = use_fixed ? fixed_tx : 8'($urandom);
        tx_data = cur;
        load0   = tx_load_cnt;
        bus_start();
        check({tag, "_busy_after_start"}, busy, 1'b0);
        write_byte(8'hA1, ack);
        check({tag, "_addr_ack"}, ack, 1'b1);
        check({tag, "_rx_rw"}, rx_rw, 1'b1);
        check({tag, "_busy"}, busy, 1'b1);
        for (int i = 0; i < nbytes; i++) begin
            nxt = use_fixed ? fixed_tx : 8'($urandom);
            read_byte(i != nbytes - 1, nxt, got);
            check({tag, "_rd_byte"}, got, cur);
            cur = nxt;
        end
        check({tag, "_sda_released_after_nack"}, sda, 1'b1);
        bus_stop();
        check({tag, "_tx_loads"}, tx_load_cnt - load0, nbytes);
        check({tag, "_busy_after_stop"}, busy, 1'b0);
        compare_rx(tag);
        $display("txn %s read bytes=%0d", tag, nbytes);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic       found;
        logic [7:0] rnd_addr;
        int         low0;

        // Reset values
        #20;
        check("rst_sda", sda, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_rw", rx_rw, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_tx_load", tx_load, 1'b0);
        #10 rst = 1'b1;
        #90;

        // Write 0xA5 to our address
        write_txn(8'hA0, 1, 1'b1, 8'hA5, "wr_a5");

        // Randomized writes
        for (int t = 0; t < 3; t++)
            write_txn(8'hA0, $urandom_range(1, 3), 1'b0, 8'h00, "wr_rand");

        // Wrong address 0x51 followed by a data byte
        write_txn(8'hA2, 1, 1'b0, 8'h00, "addr_51");

        // Randomized non-matching addresses
        for (int t = 0; t < 3; t++) begin
            rnd_addr = {7'($urandom_range(0, 127)), 1'b0};
            if (rnd_addr[7:1] == 7'h50) rnd_addr[7:1] = 7'h2A;
            write_txn(rnd_addr, 1, 1'b0, 8'h00, "addr_rand");
        end

        // Read 0x3C twice, ACK then NACK
        read_txn(2, 1'b1, 8'h3C, "rd_3c");

        // Randomized reads
        for (int t = 0; t < 2; t++)
            read_txn($urandom_range(1, 3), 1'b0, 8'h00, "rd_rand");

        // STOP after 4 data bits discards the partial byte
        bus_start();
        write_byte(8'hA0, ack);
        check("partial_addr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) clock_bit(1'($urandom), s);
        bus_stop();
        check("partial_sda", sda, 1'b1);
        check("partial_busy", busy, 1'b0);
        compare_rx("partial");
        $display("txn partial write then stop");
        write_txn(8'hA0, 1, 1'b0, 8'h00, "after_partial");

        // Repeated START in WR_DATA, then read
        bus_start();
        write_byte(8'hA0, ack);
        check("rs_wr_addr_ack", ack, 1'b1);
        for (int i = 0; i < 3; i++) clock_bit(1'($urandom), s);
        read_txn(1, 1'b0, 8'h00, "rs_read");

        // Reset while the slave drives the address ACK
        tx_data = 8'h5A;
        bus_start();
        for (int i = 7; i >= 0; i--) clock_bit(rnd_addr[i] ^ rnd_addr[i] ^ 1'(8'hA1 >> i), s);
        m_sda_low = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge sys_clk);
            if (sda === 1'b0) found = 1'b1;
        end
        check("rst_mid_ack_seen", found, 1'b1);
        check("rst_mid_rx_rw_before", rx_rw, 1'b1);
        #3 rst = 1'b0;
        #1;
        check("rst_mid_sda", sda, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_rx_rw", rx_rw, 1'b0);
        check("rst_mid_rx_data", rx_data, 8'h00);
        check("rst_mid_rx_valid", rx_valid, 1'b0);
        check("rst_mid_tx_load", tx_load, 1'b0);
        $display("txn reset during ack");
        #6;
        #40 rst = 1'b1;
        #40;
        // Without a START the slave must ignore an address-shaped byte
        low0 = slave_low_cnt;
        write_byte(8'hA0, ack);
        check("no_start_ack", ack, 1'b0);
        check("no_start_never_low", slave_low_cnt - low0, 0);
        bus_stop();
        got_q.delete();
        write_txn(8'hA0, 2, 1'b0, 8'h00, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
- REQ-001 SLAVE_ADDR, 7'h50, 7-bit address this slave responds to.
- REQ-002 SYNC_STAGES, 2, synchronizer depth on scl and sda inputs (min 2).
- REQ-003 sys_clk  input  1  system clock; every register is clocked on its rising edge.
- REQ-004 rst  input  1  reset, asynchronous, active-low.
- REQ-005 scl  input  1  I2C clock from the bus master; asynchronous to sys_clk.
- REQ-006 sda  inout  1  I2C data line; open-drain: the slave drives 0 or high-Z only, never 1.
- REQ-007 tx_data  input  8  byte returned on a read; captured on tx_load.
- REQ-008 tx_load  output  1  one-cycle pulse when tx_data is sampled into the shift register.
- REQ-009 rx_data  output  8  last byte received on a write; holds until the next rx_valid.
- REQ-010 rx_valid  output  1  one-cycle pulse when rx_data updates.
- REQ-011 rx_rw  output  1  R/W bit of the last matched address byte.
- REQ-012 busy  output  1  high from a matched address ACK until STOP, repeated START or mismatch.

Function
- REQ-013 scl and sda SHALL pass through SYNC_STAGES flops; all edge and condition detection SHALL use the synchronized copies.
- REQ-014 START SHALL be detected as a falling edge on synchronized sda while synchronized scl is high; STOP SHALL be detected as a rising edge on sda while scl is high.
- REQ-015 Data bits SHALL be sampled on the scl rising edge; the slave SHALL change its sda drive only on the cycle after an scl falling edge.
- REQ-016 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- REQ-017 IDLE -> ADDR on START; a 3-bit counter SHALL reset to 0; bits SHALL be shifted in MSB first.
- REQ-018 ADDR: after the 8th rising edge, if bits[7:1]==SLAVE_ADDR go to ADDR_ACK, else go to IDLE with sda released.
- REQ-019 ADDR_ACK: drive sda low from the next scl falling edge through the following falling edge; then go to WR_DATA if rw=0, or RD_DATA if rw=1.
- REQ-020 rx_rw SHALL update and busy SHALL assert in the cycle the match is decided.
- REQ-021 On entry to RD_DATA, tx_load SHALL pulse and tx_data SHALL be captured; the MSB SHALL be driven (0 = low, 1 = high-Z) in that same cycle.
- REQ-022 WR_DATA: after the 8th rising edge, rx_data SHALL be updated and rx_valid pulsed in the next cycle; then go to WR_ACK.
- REQ-023 WR_ACK SHALL ACK exactly as in ADDR_ACK, then return to WR_DATA; multi-byte writes are unbounded.
- REQ-024 RD_DATA: after the 8th bit's falling edge, release sda and go to RD_ACK.
- REQ-025 RD_ACK: sample the master's bit on the rising edge; on ACK (0) go to RD_DATA with a new tx_load; on NACK (1) go to IDLE and release sda.
- REQ-026 STOP in any state SHALL go to IDLE, release sda, clear busy, and discard any partial byte (no rx_valid).
- REQ-027 START in any non-IDLE state is a repeated START: go to ADDR, release sda, clear busy.
- REQ-028 If START/STOP and a data edge are detected in the same cycle, START/STOP SHALL win.
- REQ-029 Correct operation requires scl high and low phases of at least SYNC_STAGES+2 sys_clk cycles.

Reset
- REQ-030 On rst low: state=IDLE, sda released (high-Z), rx_data=0, rx_valid=0, rx_rw=0, busy=0, tx_load=0, counters 0, synchronizers 1.
- REQ-031 Reset asserted mid-transfer SHALL release sda immediately (asynchronously); after release the slave SHALL wait for a new START.

Structure
- REQ-032 A shared package i2c_pkg SHALL hold the state encoding typedef and the default address constant; i2c_master states are not reused.
- REQ-033 One sub-module, i2c_bus_sync, SHALL contain the synchronizers and the scl rise/fall and START/STOP detection; the FSM and shift logic SHALL live in i2c_slave.

Verification
- REQ-034 Write 0x50/W, then data 0xA5, then STOP -> sda low on both 9th clocks; one rx_valid with rx_data=0xA5; busy=0 after STOP.
- REQ-035 Address 0x51 -> sda never driven low; state IDLE; no rx_valid; busy stays 0.
- REQ-036 Read 0x50/R with tx_data=0x3C; master ACKs byte 1 and NACKs byte 2 -> sda shows 0x3C twice; two tx_load pulses; sda released after the NACK.
- REQ-037 STOP after 4 data bits -> no rx_valid; IDLE; sda released.
- REQ-038 Repeated START during WR_DATA, then 0x50/R -> ACK; rx_rw=1; read proceeds normally.
- REQ-039 rst low while the slave is driving ACK -> sda high-Z in the same cycle; all outputs at reset values.
